// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the board run sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        PASS,
        FAIL
    } run_state_t;

    localparam int unsigned LED_BUSY = 0;
    localparam int unsigned LED_BEAT = 1;
    localparam int unsigned LED_PASS = 2;
    localparam int unsigned LED_FAIL = 3;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse on its rising edge.
module sync_rise #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resetting to RESET_VAL=1 keeps a level already high at reset release from firing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/run_controller.sv
// Run sequencer: switch launch -> fixed core reset pulse -> run with timeout -> pass/fail LEDs.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 1_000_000,
    parameter int unsigned BLINK_LOG2 = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        core_done,
    output logic        core_reset,
    output logic        busy,
    output logic [31:0] cycles,
    output logic [3:0]  led
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t              r_state;
    run_state_t              w_state_next;
    logic [HOLD_W-1:0]       r_hold;
    logic [HOLD_W-1:0]       w_hold_next;
    logic [31:0]             r_cycles;
    logic [31:0]             w_cycles_next;
    logic [BLINK_LOG2-1:0]   r_beat;
    logic                    w_launch;

    sync_rise #(
        .RESET_VAL (1'b1)
    ) u_start_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (start),
        .o_rise  (w_launch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_cycles <= '0;
            r_beat   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_hold   <= w_hold_next;
            r_cycles <= w_cycles_next;
            r_beat   <= r_beat + BLINK_LOG2'(1);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = r_hold;
        w_cycles_next = r_cycles;
        case (r_state)
            IDLE, PASS, FAIL: begin
                if (w_launch) begin
                    w_state_next  = HOLD;
                    w_hold_next   = HOLD_W'(RST_CYCLES - 1);
                    w_cycles_next = '0;
                end
            end
            HOLD: begin
                if (r_hold == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_hold_next = r_hold - HOLD_W'(1);
                end
            end
            RUN: begin
                // Done takes priority over a timeout landing on the same edge.
                if (core_done) begin
                    w_state_next = PASS;
                end else if (r_cycles == 32'(TIMEOUT - 1)) begin
                    w_state_next  = FAIL;
                    w_cycles_next = TIMEOUT;
                end else begin
                    w_cycles_next = r_cycles + 32'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so there is no input-to-output path.
    always_comb begin
        core_reset         = (r_state != RUN);
        busy               = (r_state == HOLD) || (r_state == RUN);
        cycles             = r_cycles;
        led                = '0;
        led[LED_BUSY]      = busy;
        led[LED_BEAT]      = (r_state == RUN) && r_beat[BLINK_LOG2-1];
        led[LED_PASS]      = (r_state == PASS);
        led[LED_FAIL]      = (r_state == FAIL);
    end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller with RST_CYCLES=4, TIMEOUT=20, BLINK_LOG2=3.
module tb_run_controller;

    localparam int unsigned RST_CYCLES = 4;
    localparam int unsigned TIMEOUT    = 20;
    localparam int unsigned BLINK_LOG2 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic        core_done = 1'b0;
    logic        core_reset;
    logic        busy;
    logic [31:0] cycles;
    logic [3:0]  led;

    typedef struct packed {
        logic        cr;
        logic        bsy;
        logic [31:0] cyc;
        logic [3:0]  led;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    logic [2:0] tb_beat;

    run_controller #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_done  (core_done),
        .core_reset (core_reset),
        .busy       (busy),
        .cycles     (cycles),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Reference heartbeat: free-running count of clock edges since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_beat <= '0;
        else       tb_beat <= tb_beat + 3'd1;
    end

    // Monitor: compares every queued expectation on the falling edge.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests_run++;
            if (core_reset !== e.cr || busy !== e.bsy || cycles !== e.cyc || led !== e.led) begin
                tests_failed++;
                $display("FAIL %s: got core_reset=%0b busy=%0b cycles=%0d led=%b, expected core_reset=%0b busy=%0b cycles=%0d led=%b",
                         n, core_reset, busy, cycles, led, e.cr, e.bsy, e.cyc, e.led);
            end
        end
    end

    task automatic expect_out(input string name, input logic cr, input logic bsy,
                              input logic [31:0] cyc, input logic [3:0] l);
        exp_t e;
        e.cr  = cr;
        e.bsy = bsy;
        e.cyc = cyc;
        e.led = l;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] run_led();
        return {2'b00, tb_beat[2], 1'b1};
    endfunction

    task automatic run_to(input int from, input int to);
        for (int c = from + 1; c <= to; c++) begin
            tick();
            expect_out("run_count", 1'b0, 1'b1, 32'(c), run_led());
        end
    endtask

    // Drop the switch, raise it, and follow the launch through HOLD into RUN.
    task automatic launch(input logic [31:0] prev_cyc, input logic [3:0] prev_led);
        start = 1'b0;
        repeat (3) begin
            tick();
            expect_out("idle_wait", 1'b1, 1'b0, prev_cyc, prev_led);
        end
        start = 1'b1;
        repeat (2) begin
            tick();
            expect_out("pre_launch", 1'b1, 1'b0, prev_cyc, prev_led);
        end
        tick();
        expect_out("hold_entry", 1'b1, 1'b1, 32'd0, 4'b0001);
        repeat (RST_CYCLES - 1) begin
            tick();
            expect_out("hold", 1'b1, 1'b1, 32'd0, 4'b0001);
        end
        tick();
        expect_out("run_entry", 1'b0, 1'b1, 32'd0, run_led());
    endtask

    task automatic finish_pass(input logic [31:0] cyc);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        expect_out("pass", 1'b1, 1'b0, cyc, 4'b0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b1;
        repeat (2) tick();
        expect_out("reset_hold", 1'b1, 1'b0, 32'd0, 4'b0000);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (10) tick();
            expect_out("idle_switch_high", 1'b1, 1'b0, 32'd0, 4'b0000);
        end

        // First run: done after 7 RUN cycles.
        launch(32'd0, 4'b0000);
        run_to(0, 7);
        finish_pass(32'd7);

        // Relaunch from PASS clears cycles; done after 3.
        launch(32'd7, 4'b0100);
        run_to(0, 3);
        finish_pass(32'd3);

        // Timeout.
        launch(32'd3, 4'b0100);
        run_to(0, TIMEOUT - 1);
        tick();
        expect_out("timeout_fail", 1'b1, 1'b0, 32'(TIMEOUT), 4'b1000);
        repeat (2) begin
            tick();
            expect_out("fail_hold", 1'b1, 1'b0, 32'(TIMEOUT), 4'b1000);
        end

        // Done and timeout on the same edge: done wins.
        launch(32'(TIMEOUT), 4'b1000);
        run_to(0, TIMEOUT - 1);
        finish_pass(32'(TIMEOUT - 1));

        // Switch toggled during RUN is ignored and not queued.
        launch(32'(TIMEOUT - 1), 4'b0100);
        run_to(0, 2);
        start = 1'b0;
        run_to(2, 4);
        start = 1'b1;
        run_to(4, 7);
        finish_pass(32'd7);
        repeat (4) begin
            tick();
            expect_out("no_queued_launch", 1'b1, 1'b0, 32'd7, 4'b0100);
        end

        // Asynchronous reset between clock edges.
        launch(32'd7, 4'b0100);
        run_to(0, 2);
        tick();
        #2;
        reset = 1'b1;
        expect_out("async_reset", 1'b1, 1'b0, 32'd0, 4'b0000);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        expect_out("post_reset_idle", 1'b1, 1'b0, 32'd0, 4'b0000);

        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
